// File: rtl/inst_cache_dm_pkg.sv
// Shared definitions for the direct-mapped caches: FSM encoding, default geometry
// and the tag-width derivation used by both the instruction and data caches.
package inst_cache_dm_pkg;

   typedef enum logic {
      IC_IDLE = 1'b0,
      IC_MISS = 1'b1
   } ic_state_e;

   localparam int IC_INDEX_BITS = 4;
   localparam int IC_ADDR_BITS  = 32;

   // Tag is whatever remains of a 32-bit byte address above the index and word offset.
   function automatic int ic_tag_bits(input int index_bits);
      return IC_ADDR_BITS - index_bits - 2;
   endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for a one-word-per-line direct-mapped cache.
// One combinational read port (lookup) and one synchronous write port (fill).
module icache_line_array
   import inst_cache_dm_pkg::*;
#(
   parameter int INDEX_BITS = IC_INDEX_BITS,
   parameter int TAG_BITS   = ic_tag_bits(IC_INDEX_BITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [31:0]           wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   // Only the valid bits are reset; stale tag/data are harmless once invalid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   always_comb begin
      rd_valid = valid_q[rd_index];
      rd_tag   = tag_mem[rd_index];
      rd_data  = data_mem[rd_index];
   end

endmodule

// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache between InstFetch and MemCtrl: 1-cycle hits,
// single-word fill on a miss. rdy low freezes every register in the block.
module inst_cache_dm
   import inst_cache_dm_pkg::*;
#(
   parameter int INDEX_BITS = IC_INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_valid,
   input  logic [31:0] pc_from_if,
   output logic        inst_enable,
   output logic [31:0] inst_to_if,
   output logic        addr_enable,
   output logic [31:0] addr_to_mem,
   input  logic        mem_valid,
   input  logic [31:0] inst_from_mem,
   output ic_state_e   state_dbg
);

   localparam int TAG_BITS = ic_tag_bits(INDEX_BITS);

   // Handshakes: IF holds if_valid/pc until it sees a one-cycle inst_enable.
   // The cache holds addr_enable/addr_to_mem until a one-cycle mem_valid.
   ic_state_e             state_q;
   logic [31:2]           miss_pc_q;

   logic [INDEX_BITS-1:0] lookup_index;
   logic [TAG_BITS-1:0]   lookup_tag;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [31:0]           rd_data;
   logic                  hit;
   logic                  fill_en;
   logic                  unused_pc_bits;

   assign lookup_index   = pc_from_if[INDEX_BITS+1:2];
   assign lookup_tag     = pc_from_if[31:INDEX_BITS+2];
   assign hit            = rd_valid && (rd_tag == lookup_tag);
   assign unused_pc_bits = ^pc_from_if[1:0];

   // Fill only from MISS, so a stray mem_valid while IDLE never touches the array.
   assign fill_en = rdy && (state_q == IC_MISS) && mem_valid;

   icache_line_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_lines (
      .clk      (clk),
      .rst      (rst),
      .rd_index (lookup_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (fill_en),
      .wr_index (miss_pc_q[INDEX_BITS+1:2]),
      .wr_tag   (miss_pc_q[31:INDEX_BITS+2]),
      .wr_data  (inst_from_mem)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IC_IDLE;
         miss_pc_q   <= '0;
         inst_enable <= 1'b0;
         inst_to_if  <= '0;
         addr_enable <= 1'b0;
         addr_to_mem <= '0;
      end else if (rdy) begin
         case (state_q)
            IC_IDLE: begin
               if (if_valid && hit) begin
                  inst_enable <= 1'b1;
                  inst_to_if  <= rd_data;
               end else if (if_valid) begin
                  inst_enable <= 1'b0;
                  addr_enable <= 1'b1;
                  addr_to_mem <= {pc_from_if[31:2], 2'b00};
                  miss_pc_q   <= pc_from_if[31:2];
                  state_q     <= IC_MISS;
               end else begin
                  inst_enable <= 1'b0;
               end
            end
            IC_MISS: begin
               // IF may have jumped; the outstanding fetch still completes.
               if (mem_valid) begin
                  inst_enable <= 1'b1;
                  inst_to_if  <= inst_from_mem;
                  addr_enable <= 1'b0;
                  state_q     <= IC_IDLE;
               end else begin
                  inst_enable <= 1'b0;
               end
            end
            default: begin
               state_q     <= IC_IDLE;
               inst_enable <= 1'b0;
               addr_enable <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed bench for inst_cache_dm: reset, cold miss/hit, conflict eviction,
// jump during miss, rdy stall and reset mid-miss.
module tb_inst_cache_dm;
   import inst_cache_dm_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        if_valid = 1'b0;
   logic [31:0] pc_from_if = '0;
   logic        inst_enable;
   logic [31:0] inst_to_if;
   logic        addr_enable;
   logic [31:0] addr_to_mem;
   logic        mem_valid = 1'b0;
   logic [31:0] inst_from_mem = '0;
   ic_state_e   state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   inst_cache_dm dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .if_valid      (if_valid),
      .pc_from_if    (pc_from_if),
      .inst_enable   (inst_enable),
      .inst_to_if    (inst_to_if),
      .addr_enable   (addr_enable),
      .addr_to_mem   (addr_to_mem),
      .mem_valid     (mem_valid),
      .inst_from_mem (inst_from_mem),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [31:0] pc, input logic [31:0] word, input int lat,
                          input string tag);
      logic [31:0] aligned;
      aligned    = {pc[31:2], 2'b00};
      if_valid   = 1'b1;
      pc_from_if = pc;
      step();
      check_eq({tag, ":miss_ae"}, 32'(addr_enable), 32'd1);
      check_eq({tag, ":miss_addr"}, addr_to_mem, aligned);
      check_eq({tag, ":miss_ie"}, 32'(inst_enable), 32'd0);
      for (int i = 1; i < lat; i++) begin
         step();
         check_eq({tag, ":hold_ae"}, 32'(addr_enable), 32'd1);
      end
      mem_valid     = 1'b1;
      inst_from_mem = word;
      step();
      mem_valid     = 1'b0;
      inst_from_mem = $urandom;
      check_eq({tag, ":fill_ie"}, 32'(inst_enable), 32'd1);
      check_eq({tag, ":fill_data"}, inst_to_if, word);
      check_eq({tag, ":fill_ae"}, 32'(addr_enable), 32'd0);
      if_valid = 1'b0;
      step();
      check_eq({tag, ":after_ie"}, 32'(inst_enable), 32'd0);
   endtask

   task automatic do_hit(input logic [31:0] pc, input logic [31:0] exp, input string tag);
      if_valid   = 1'b1;
      pc_from_if = pc;
      step();
      check_eq({tag, ":hit_ie"}, 32'(inst_enable), 32'd1);
      check_eq({tag, ":hit_data"}, inst_to_if, exp);
      check_eq({tag, ":hit_ae"}, 32'(addr_enable), 32'd0);
      if_valid = 1'b0;
      step();
      check_eq({tag, ":hit_after_ie"}, 32'(inst_enable), 32'd0);
   endtask

   initial begin
      // 1: reset held with a pending request
      if_valid   = 1'b1;
      pc_from_if = 32'h0;
      repeat (3) step();
      check_eq("rst:ie", 32'(inst_enable), 32'd0);
      check_eq("rst:ae", 32'(addr_enable), 32'd0);
      check_eq("rst:addr", addr_to_mem, 32'h0);
      check_eq("rst:data", inst_to_if, 32'h0);
      check_eq("rst:state", 32'(state_dbg), 32'(IC_IDLE));
      if_valid = 1'b0;
      rst      = 1'b1;
      step();
      do_miss(32'h0000_0000, 32'h1111_0000, 2, "t1_pc0");

      // 2: cold miss then hit, plus back-to-back hits on two lines
      do_miss(32'h0000_1004, 32'h0050_0093, 3, "t2_cold");
      do_hit(32'h0000_1004, 32'h0050_0093, "t2_hit");
      if_valid   = 1'b1;
      pc_from_if = 32'h0000_1004;
      step();
      check_eq("t2_b2b0", inst_to_if, 32'h0050_0093);
      pc_from_if = 32'h0000_0000;
      step();
      check_eq("t2_b2b1_ie", 32'(inst_enable), 32'd1);
      check_eq("t2_b2b1", inst_to_if, 32'h1111_0000);
      if_valid = 1'b0;
      step();

      // 3: 0x40 and 0x80 share index 0
      do_miss(32'h0000_0040, 32'hAAAA_0040, 2, "t3_a");
      do_miss(32'h0000_0080, 32'hBBBB_0080, 2, "t3_b");
      do_hit(32'h0000_0080, 32'hBBBB_0080, "t3_bhit");
      do_miss(32'h0000_0040, 32'hAAAA_0041, 1, "t3_evict");
      do_hit(32'h0000_1004, 32'h0050_0093, "t3_other");

      // 4: jump to 0x3000 while the 0x2000 fill is outstanding
      if_valid   = 1'b1;
      pc_from_if = 32'h0000_2000;
      step();
      check_eq("t4:ae", 32'(addr_enable), 32'd1);
      pc_from_if = 32'h0000_3000;
      step();
      check_eq("t4:hold_addr", addr_to_mem, 32'h0000_2000);
      check_eq("t4:state", 32'(state_dbg), 32'(IC_MISS));
      mem_valid     = 1'b1;
      inst_from_mem = 32'h2222_2000;
      step();
      mem_valid = 1'b0;
      check_eq("t4:fill_ie", 32'(inst_enable), 32'd1);
      check_eq("t4:fill_data", inst_to_if, 32'h2222_2000);
      step();
      check_eq("t4:jump_ae", 32'(addr_enable), 32'd1);
      check_eq("t4:jump_addr", addr_to_mem, 32'h0000_3000);
      check_eq("t4:jump_ie", 32'(inst_enable), 32'd0);
      mem_valid     = 1'b1;
      inst_from_mem = 32'h3333_3000;
      step();
      mem_valid = 1'b0;
      if_valid  = 1'b0;
      check_eq("t4:jfill", inst_to_if, 32'h3333_3000);
      step();
      do_hit(32'h0000_3000, 32'h3333_3000, "t4_hit");

      // 5: rdy low while mem_valid pulses -> nothing moves
      if_valid   = 1'b1;
      pc_from_if = 32'h0000_4008;
      step();
      check_eq("t5:ae", 32'(addr_enable), 32'd1);
      rdy           = 1'b0;
      mem_valid     = 1'b1;
      inst_from_mem = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t5:stall_ae", 32'(addr_enable), 32'd1);
         check_eq("t5:stall_ie", 32'(inst_enable), 32'd0);
         check_eq("t5:stall_addr", addr_to_mem, 32'h0000_4008);
      end
      mem_valid = 1'b0;
      rdy       = 1'b1;
      step();
      check_eq("t5:resume_ae", 32'(addr_enable), 32'd1);
      check_eq("t5:resume_state", 32'(state_dbg), 32'(IC_MISS));
      mem_valid     = 1'b1;
      inst_from_mem = 32'h4444_4008;
      step();
      mem_valid = 1'b0;
      if_valid  = 1'b0;
      check_eq("t5:fill_ie", 32'(inst_enable), 32'd1);
      check_eq("t5:fill_data", inst_to_if, 32'h4444_4008);
      step();
      do_hit(32'h0000_4008, 32'h4444_4008, "t5_hit");

      // 6: async reset mid-miss, late mem_valid ignored, old lines gone
      if_valid   = 1'b1;
      pc_from_if = 32'h0000_5000;
      step();
      check_eq("t6:ae", 32'(addr_enable), 32'd1);
      if_valid = 1'b0;
      rst      = 1'b0;
      #1;
      check_eq("t6:async_ae", 32'(addr_enable), 32'd0);
      check_eq("t6:async_state", 32'(state_dbg), 32'(IC_IDLE));
      step();
      rst           = 1'b1;
      mem_valid     = 1'b1;
      inst_from_mem = 32'h5555_5000;
      step();
      mem_valid = 1'b0;
      check_eq("t6:late_ie", 32'(inst_enable), 32'd0);
      check_eq("t6:late_ae", 32'(addr_enable), 32'd0);
      do_miss(32'h0000_1004, 32'h0050_0093, 2, "t6_1004");
      do_miss(32'h0000_4008, 32'h4444_4008, 1, "t6_4008");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
